mole_hit_judge: RTL

Judges player button presses against the currently displayed mole and produces single-cycle hit/miss strobes. Sits directly upstream of the score counter, whose `hit_pulse` input is driven by this block's `hit_pulse`. It also consumes the mole generator's position and visibility, and returns a `whacked` level so the generator can hide a struck mole early. It enforces one hit per mole appearance and a penalty lockout after a miss.

---
 rtl/mole_hit_judge_pkg.sv | 22 ++
 rtl/mole_hit_judge_btn_edge_detect.sv | 28 ++
 rtl/mole_hit_judge.sv | 118 +++++++++++
 3 files changed

// File: rtl/mole_hit_judge_pkg.sv
// Shared game definitions: judge FSM encoding and board-size defaults
// used by the mole generator, display and hit judge.
`default_nettype none

package mole_hit_judge_pkg;

  localparam int C_N_HOLES = 9;
  localparam int C_IDX_W   = 4;

  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_ARMED   = 2'd1;
  localparam logic [1:0] C_ST_WHACKED = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = C_ST_IDLE,
    ARMED   = C_ST_ARMED,
    WHACKED = C_ST_WHACKED
  } judge_state_e;

endpackage : mole_hit_judge_pkg

`default_nettype wire

// File: rtl/mole_hit_judge_btn_edge_detect.sv
// Rising-edge detector for the button bank; the all-ones reset makes a
// button held through reset look already pressed, so it never fires.
`default_nettype none

module btn_edge_detect #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons_i,
  output logic [WIDTH-1:0] press_o
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= '1;
    end else begin
      btn_q <= buttons_i;
    end
  end

  assign press_o = buttons_i & ~btn_q;

endmodule : btn_edge_detect

`default_nettype wire

// File: rtl/mole_hit_judge.sv
// Judges button presses against the visible mole: one hit per appearance,
// registered hit/miss strobes and a penalty lockout after each miss.
`default_nettype none

module mole_hit_judge
  import mole_hit_judge_pkg::*;
#(
  parameter int N_HOLES        = C_N_HOLES,
  parameter int IDX_W          = C_IDX_W,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int LOCK_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [N_HOLES-1:0] buttons_i,
  input  logic               mole_up_i,
  input  logic [IDX_W-1:0]   mole_idx_i,
  output logic               hit_pulse_o,
  output logic               miss_pulse_o,
  output logic               whacked_o,
  output logic               locked_o
);

  localparam logic [IDX_W:0]  C_N_HOLES_EXT = (IDX_W+1)'(N_HOLES);
  localparam logic [LOCK_W-1:0] C_LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

  judge_state_e       state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               whacked_q;
  logic               locked_q;

  logic [N_HOLES-1:0] w_press;
  logic [N_HOLES-1:0] w_target;
  logic               w_valid;
  logic               w_idx_ok;

  btn_edge_detect #(
    .WIDTH (N_HOLES)
  ) u_btn_edge_detect (
    .clk       (clk),
    .rst       (rst),
    .buttons_i (buttons_i),
    .press_o   (w_press)
  );

  assign w_idx_ok = ({1'b0, mole_idx_i} < C_N_HOLES_EXT);
  assign w_target = N_HOLES'(1) << cur_idx_q;
  assign w_valid  = enable_i && (lock_q == '0) && (w_press != '0);

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    lock_d    = (lock_q != '0) ? lock_q - LOCK_W'(1) : '0;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
      lock_d  = '0;
    end else begin
      // The press is judged against the pre-edge state; mole movement
      // below then overrides the state it lands in.
      if (w_valid) begin
        if (state_q == ARMED && w_press == w_target) begin
          hit_d   = 1'b1;
          state_d = WHACKED;
        end else begin
          miss_d = 1'b1;
          lock_d = C_LOCK_LOAD;
        end
      end

      if (state_q == IDLE) begin
        if (mole_up_i && w_idx_ok) begin
          state_d   = ARMED;
          cur_idx_d = mole_idx_i;
        end
      end else if (!mole_up_i || !w_idx_ok) begin
        state_d = IDLE;
      end else if (mole_idx_i != cur_idx_q) begin
        state_d   = ARMED;
        cur_idx_d = mole_idx_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      lock_q    <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      whacked_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      lock_q    <= lock_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      whacked_q <= (state_d == WHACKED);
      locked_q  <= (lock_d != '0);
    end
  end

  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = miss_q;
  assign whacked_o    = whacked_q;
  assign locked_o     = locked_q;

endmodule : mole_hit_judge

`default_nettype wire
